// File: rtl/detection_gate_pkg.sv
// Shared ultrasonic system definitions: detection FSM encoding, timer and
// counter widths, and a saturating increment helper.
package detection_gate_pkg;

  localparam int NUM_W    = 60;
  localparam int DEN_W    = 50;
  localparam int THRESH_W = 10;
  localparam int TIMER_W  = 14;
  localparam int COUNT_W  = 8;
  localparam int RUN_W    = 8;
  localparam int HOLD_W   = 8;

  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DETECT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } gate_state_e;

  // Increment an 8-bit event counter, sticking at all-ones.
  function automatic logic [COUNT_W-1:0] sat_inc8(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/detection_gate.sv
// Threshold detection gate: qualifies runs of above-threshold filter samples,
// emits one FIFO write pulse per qualifying run, then ignores a hold-off window.
module detection_gate
  import detection_gate_pkg::*;
#(
  parameter logic [7:0] MIN_LEN = 8'd4,
  parameter logic [7:0] HOLDOFF = 8'd32
) (
  input  logic                SYS_CLK,
  input  logic                RST,
  input  logic                NIOS_ADC_ON,
  input  logic                CLK_EN,
  input  logic [NUM_W-1:0]    Yn_NUM,
  input  logic [DEN_W-1:0]    Yn_DEN,
  input  logic [THRESH_W-1:0] THRESH,
  input  logic                PEAK_FIFO_FULL,
  output logic                DETECTION,
  output logic                ABS_PEAK_FLAG,
  output logic [TIMER_W-1:0]  TIMER,
  output logic                TIMER_OVF,
  output logic [COUNT_W-1:0]  DET_COUNT,
  output logic [COUNT_W-1:0]  DROP_COUNT
);

  gate_state_e        state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] det_cnt_q, det_cnt_d;
  logic [COUNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic               flag_q, flag_d;
  logic               detection_q;

  // Full-width ratio test: NUM/DEN > THRESH rewritten as NUM > THRESH*DEN.
  logic [NUM_W-1:0] thresh_prod;
  logic             above;
  assign thresh_prod = NUM_W'(THRESH) * NUM_W'(Yn_DEN);
  assign above       = (Yn_NUM > thresh_prod);

  // Next-state, sample timer, run/hold-off counters and flag decision.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    hold_d     = hold_q;
    timer_d    = timer_q;
    ovf_d      = ovf_q;
    det_cnt_d  = det_cnt_q;
    drop_cnt_d = drop_cnt_q;
    flag_d     = 1'b0;

    if (!NIOS_ADC_ON) begin
      // Acquisition off wins over any coincident sample; a pending run is lost.
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_ARMED;
      timer_d    = '0;
      ovf_d      = 1'b0;
      det_cnt_d  = '0;
      drop_cnt_d = '0;
      run_d      = '0;
      hold_d     = '0;
    end else if (CLK_EN) begin
      if (timer_q != TIMER_MAX) begin
        timer_d = timer_q + TIMER_W'(1);
      end
      if (timer_d == TIMER_MAX) begin
        ovf_d = 1'b1;
      end

      case (state_q)
        ST_ARMED: begin
          if (above) begin
            state_d = ST_DETECT;
            run_d   = RUN_W'(1);
          end
        end
        ST_DETECT: begin
          if (above) begin
            run_d = sat_inc8(run_q);
          end else if (run_q >= MIN_LEN) begin
            state_d = ST_HOLDOFF;
            hold_d  = '0;
            if (PEAK_FIFO_FULL) begin
              drop_cnt_d = sat_inc8(drop_cnt_q);
            end else begin
              flag_d    = 1'b1;
              det_cnt_d = sat_inc8(det_cnt_q);
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_HOLDOFF: begin
          // Samples are ignored here; leave on the HOLDOFF-th strobe.
          if ((hold_q + HOLD_W'(1)) == HOLDOFF) begin
            state_d = ST_ARMED;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset overrides everything, so no flag escapes.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      hold_q      <= '0;
      timer_q     <= '0;
      ovf_q       <= 1'b0;
      det_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      flag_q      <= 1'b0;
      detection_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      hold_q      <= hold_d;
      timer_q     <= timer_d;
      ovf_q       <= ovf_d;
      det_cnt_q   <= det_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      flag_q      <= flag_d;
      detection_q <= (state_d == ST_DETECT);
    end
  end

  assign DETECTION     = detection_q;
  assign ABS_PEAK_FLAG = flag_q;
  assign TIMER         = timer_q;
  assign TIMER_OVF     = ovf_q;
  assign DET_COUNT     = det_cnt_q;
  assign DROP_COUNT    = drop_cnt_q;

endmodule

// File: tb/tb_detection_gate.sv
// Self-checking bench for detection_gate: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a sample-level model.
module tb_detection_gate;

  localparam int MIN_LEN_TB = 4;
  localparam int HOLD_TB    = 32;
  localparam int TMAX       = 16383;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        NIOS_ADC_ON = 1'b0;
  logic        CLK_EN = 1'b0;
  logic [59:0] Yn_NUM = '0;
  logic [49:0] Yn_DEN = '0;
  logic [9:0]  THRESH = '0;
  logic        PEAK_FIFO_FULL = 1'b0;
  logic        DETECTION;
  logic        ABS_PEAK_FLAG;
  logic [13:0] TIMER;
  logic        TIMER_OVF;
  logic [7:0]  DET_COUNT;
  logic [7:0]  DROP_COUNT;

  detection_gate #(.MIN_LEN(8'd4), .HOLDOFF(8'd32)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .NIOS_ADC_ON(NIOS_ADC_ON), .CLK_EN(CLK_EN),
    .Yn_NUM(Yn_NUM), .Yn_DEN(Yn_DEN), .THRESH(THRESH),
    .PEAK_FIFO_FULL(PEAK_FIFO_FULL), .DETECTION(DETECTION),
    .ABS_PEAK_FLAG(ABS_PEAK_FLAG), .TIMER(TIMER), .TIMER_OVF(TIMER_OVF),
    .DET_COUNT(DET_COUNT), .DROP_COUNT(DROP_COUNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample-level model: mode 0 idle, 1 armed, 2 in a run, 3 ignoring samples.
  int m_mode = 0, m_run = 0, m_left = 0, m_timer = 0, m_det = 0, m_drop = 0;
  bit m_ovf = 0, m_flag = 0;

  task automatic model_update(input bit rst_v, input bit adc_v, input bit en_v,
                              input bit above_v, input bit full_v);
    m_flag = 0;
    if (rst_v) begin
      m_mode = 0; m_run = 0; m_left = 0; m_timer = 0; m_ovf = 0; m_det = 0; m_drop = 0;
    end else if (!adc_v) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_timer = 0; m_ovf = 0; m_det = 0; m_drop = 0; m_run = 0;
    end else if (en_v) begin
      m_timer = (m_timer >= TMAX) ? TMAX : m_timer + 1;
      if (m_timer == TMAX) m_ovf = 1;
      if (m_mode == 1) begin
        if (above_v) begin m_mode = 2; m_run = 1; end
      end else if (m_mode == 2) begin
        if (above_v) m_run = m_run + 1;
        else if (m_run >= MIN_LEN_TB) begin
          m_mode = 3;
          m_left = HOLD_TB;
          if (full_v) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
          else begin
            m_flag = 1;
            m_det = (m_det >= 255) ? 255 : m_det + 1;
          end
        end else m_mode = 1;
      end else if (m_mode == 3) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 1;
      end
    end
  endtask

  // One clock: drive inputs, clock, then compare every output to the model.
  task automatic step(input bit rst_v, input bit adc_v, input bit en_v,
                      input logic [59:0] num_v, input logic [49:0] den_v,
                      input logic [9:0] th_v, input bit full_v);
    bit [63:0] prod;
    bit        above_v;
    RST = rst_v; NIOS_ADC_ON = adc_v; CLK_EN = en_v;
    Yn_NUM = num_v; Yn_DEN = den_v; THRESH = th_v; PEAK_FIFO_FULL = full_v;
    @(posedge SYS_CLK);
    #1;
    prod    = 64'(th_v) * 64'(den_v);
    above_v = (64'(num_v) > prod);
    model_update(rst_v, adc_v, en_v, above_v, full_v);
    chk("model_DETECTION", DETECTION, (m_mode == 2) ? 1 : 0);
    chk("model_ABS_PEAK_FLAG", ABS_PEAK_FLAG, m_flag);
    chk("model_TIMER", TIMER, m_timer);
    chk("model_TIMER_OVF", TIMER_OVF, m_ovf);
    chk("model_DET_COUNT", DET_COUNT, m_det);
    chk("model_DROP_COUNT", DROP_COUNT, m_drop);
  endtask

  // Simple-ratio stimulus: THRESH=2, DEN=1, so NUM=3 is above and NUM=1 is not.
  task automatic s(input bit adc_v, input bit en_v, input bit hi, input bit full_v = 0);
    step(1'b0, adc_v, en_v, hi ? 60'd3 : 60'd1, 50'd1, 10'd2, full_v);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 60'd0, 50'd1, 10'd2, 1'b0);
  endtask

  typedef struct {
    bit rst; bit adc; bit en; bit hi; bit full;
    bit exp_det; bit exp_flag; int exp_dcnt; int exp_drop;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input bit adc, input bit en, input bit hi, input bit full,
                     input bit ed, input bit ef, input int edc, input int edr);
    vec_t v;
    v.rst = rst; v.adc = adc; v.en = en; v.hi = hi; v.full = full;
    v.exp_det = ed; v.exp_flag = ef; v.exp_dcnt = edc; v.exp_drop = edr;
    vecs.push_back(v);
  endtask

  initial begin
    bit want_hi;
    bit adc_r;
    int hi_now;

    // Basic qualifying run of 5, then a short run of 3, then a run dropped by full FIFO.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].adc, vecs[i].en, vecs[i].hi ? 60'd3 : 60'd1, 50'd1, 10'd2, vecs[i].full);
      chk("vec_DETECTION", DETECTION, vecs[i].exp_det);
      chk("vec_ABS_PEAK_FLAG", ABS_PEAK_FLAG, vecs[i].exp_flag);
      chk("vec_DET_COUNT", DET_COUNT, vecs[i].exp_dcnt);
      chk("vec_DROP_COUNT", DROP_COUNT, vecs[i].exp_drop);
    end
    $display("vector table: %0d rows applied", vecs.size());

    // Hold-off window: burst 10 samples after qualifying is ignored, burst at 40 qualifies.
    do_reset();
    s(1, 0, 0);
    for (int i = 0; i < 5; i++) s(1, 1, 1);
    s(1, 1, 0);
    chk("holdoff_first_flag", ABS_PEAK_FLAG, 1);
    for (int k = 1; k <= 45; k++) begin
      hi_now = ((k >= 10 && k <= 15) || (k >= 40 && k <= 44)) ? 1 : 0;
      s(1, 1, hi_now[0]);
      if (k >= 10 && k <= 15) chk("holdoff_burst_ignored", DETECTION, 0);
      if (k == 40) chk("holdoff_late_burst_detects", DETECTION, 1);
    end
    chk("holdoff_second_flag", ABS_PEAK_FLAG, 1);
    chk("holdoff_det_count", DET_COUNT, 2);
    $display("holdoff sequence: det_count=%0d", DET_COUNT);

    // Acquisition dropped mid-run, coincident with a sample that would qualify.
    do_reset();
    s(1, 0, 0);
    for (int i = 0; i < 5; i++) s(1, 1, 1);
    chk("abort_timer_before", TIMER, 5);
    s(0, 1, 0);
    chk("abort_detection_low", DETECTION, 0);
    chk("abort_no_flag", ABS_PEAK_FLAG, 0);
    s(0, 0, 0);
    chk("abort_no_flag_later", ABS_PEAK_FLAG, 0);
    chk("abort_det_count", DET_COUNT, 0);
    s(1, 1, 0);
    chk("reenable_timer_cleared", TIMER, 0);
    $display("abort sequence: timer after re-enable=%0d", TIMER);

    // Reset during a qualifying-length run yields no flag.
    for (int i = 0; i < 5; i++) s(1, 1, 1);
    step(1'b1, 1'b1, 1'b1, 60'd1, 50'd1, 10'd2, 1'b0);
    chk("rst_mid_detect_flag", ABS_PEAK_FLAG, 0);
    chk("rst_mid_detect_detection", DETECTION, 0);
    s(1, 0, 0);
    chk("rst_mid_detect_flag_after", ABS_PEAK_FLAG, 0);
    $display("reset-in-run sequence done");

    // Timer saturation over 16400 strobes.
    do_reset();
    s(1, 0, 0);
    for (int i = 0; i < 16400; i++) begin
      s(1, 1, 0);
      if (i == 99) chk("timer_no_ovf_early", TIMER_OVF, 0);
    end
    chk("timer_saturated", TIMER, 16383);
    chk("timer_ovf_set", TIMER_OVF, 1);
    $display("timer sequence: TIMER=%0d OVF=%0d", TIMER, TIMER_OVF);

    // Randomized traffic with bursty above/below runs and wide operands.
    do_reset();
    want_hi = 0;
    adc_r = 1;
    for (int c = 0; c < 4000; c++) begin
      logic [63:0] den64;
      logic [9:0]  th;
      bit   [63:0] prod;
      logic [59:0] num;
      int          dl;
      bit          en_r;
      if ($urandom_range(0, 199) == 0) adc_r = ~adc_r;
      else if (!adc_r && $urandom_range(0, 3) == 0) adc_r = 1;
      en_r = ($urandom_range(0, 1) == 1);
      if (en_r && $urandom_range(0, 5) == 0) want_hi = ~want_hi;
      den64 = {$urandom, $urandom};
      den64 = (den64 & 64'h0003_FFFF_FFFF_FFFF) >> $urandom_range(0, 49);
      th    = 10'($urandom_range(0, 1023));
      prod  = 64'(th) * den64;
      dl    = $urandom_range(0, 3);
      if (want_hi) num = 60'(prod + 64'(dl) + 64'd1);
      else num = (prod > 64'(dl)) ? 60'(prod - 64'(dl)) : 60'd0;
      step(($urandom_range(0, 499) == 0), adc_r, en_r, num, 50'(den64), th,
           ($urandom_range(0, 3) == 0));
    end
    $display("random phase: det_count=%0d drop_count=%0d", DET_COUNT, DROP_COUNT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/detection_gate.md
DETECTION_GATE -- requirements
Module: detection_gate

Interface
REQ-001 SHALL have parameter MIN_LEN, default 8'd4: minimum consecutive above-threshold samples for a qualifying detection.
REQ-002 SHALL have parameter HOLDOFF, default 8'd32: samples ignored after a qualifying detection; legal range 1..255.
REQ-003 SHALL have port SYS_CLK  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port NIOS_ADC_ON  in  1  acquisition enable from processor.
REQ-006 SHALL have port CLK_EN  in  1  one-cycle sample strobe, co-timed with Yn_NUM/Yn_DEN.
REQ-007 SHALL have port Yn_NUM  in  60  filter output numerator, unsigned.
REQ-008 SHALL have port Yn_DEN  in  50  filter output denominator, unsigned.
REQ-009 SHALL have port THRESH  in  10  integer threshold ratio, unsigned.
REQ-010 SHALL have port PEAK_FIFO_FULL  in  1  any downstream peak FIFO full.
REQ-011 SHALL have port DETECTION  out  1  registered; high while in DETECT.
REQ-012 SHALL have port ABS_PEAK_FLAG  out  1  one-cycle pulse commanding downstream FIFO write.
REQ-013 SHALL have port TIMER  out  14  sample index since acquisition start.
REQ-014 SHALL have port TIMER_OVF  out  1  sticky: TIMER saturated.
REQ-015 SHALL have port DET_COUNT  out  8  emitted flags, saturating.
REQ-016 SHALL have port DROP_COUNT  out  8  flags suppressed by full FIFO, saturating.

Function
REQ-017 SHALL compute ABOVE = (Yn_NUM > THRESH*Yn_DEN) combinationally; product 60 bits, no truncation; ABOVE sampled only when CLK_EN=1.
REQ-018 SHALL implement states IDLE, ARMED, DETECT, HOLDOFF; state changes only on CLK_EN cycles except entry to/exit from IDLE.
REQ-019 SHALL go to IDLE on the next cycle whenever NIOS_ADC_ON=0, from any state, aborting any detection with no flag.
REQ-020 SHALL go IDLE->ARMED on the first cycle NIOS_ADC_ON=1, clearing TIMER, TIMER_OVF, DET_COUNT, DROP_COUNT and RUN that cycle.
REQ-021 SHALL go ARMED->DETECT on CLK_EN with ABOVE=1, setting RUN=1.
REQ-022 SHALL, in DETECT on CLK_EN with ABOVE=1, increment 8-bit RUN, saturating at 255.
REQ-023 SHALL, in DETECT on CLK_EN with ABOVE=0: if RUN>=MIN_LEN go to HOLDOFF and qualify; else go to ARMED, no flag.
REQ-024 SHALL assert ABS_PEAK_FLAG exactly one SYS_CLK cycle, on the cycle after the qualifying transition, only if PEAK_FIFO_FULL=0 in the qualifying cycle; DET_COUNT increments with it.
REQ-025 SHALL, when qualifying with PEAK_FIFO_FULL=1, suppress the flag and increment DROP_COUNT.
REQ-026 SHALL, in HOLDOFF, count CLK_EN strobes and go to ARMED on the HOLDOFF-th strobe, ignoring ABOVE.
REQ-027 SHALL drive DETECTION registered: high the cycle after entering DETECT, low the cycle after leaving it.
REQ-028 SHALL increment TIMER on each CLK_EN while not IDLE; at 16383 hold and set TIMER_OVF; state machine unaffected.
REQ-029 SHALL accept CLK_EN coincident with NIOS_ADC_ON falling: IDLE takes priority, sample discarded.

Reset
REQ-030 SHALL, on RST, set state IDLE, DETECTION=0, ABS_PEAK_FLAG=0, TIMER=0, TIMER_OVF=0, DET_COUNT=0, DROP_COUNT=0, RUN=0, holdoff counter=0.
REQ-031 SHALL give RST priority over all inputs; RST mid-DETECT produces no flag.

Structure
REQ-032 SHALL place state encoding, TIMER width (14) and counter widths in the shared ultrasonic system package.
REQ-033 SHALL be a single module with no sub-modules; the threshold comparator stays inline.

Verification
REQ-034 SHALL test THRESH=2, DEN=1, NUM=3 for 5 strobes then NUM=1 -> DETECTION high 5 samples, one ABS_PEAK_FLAG pulse, DET_COUNT=1.
REQ-035 SHALL test run of 3 above-threshold samples with MIN_LEN=4 -> DETECTION pulses, no flag, state ARMED.
REQ-036 SHALL test qualifying run with PEAK_FIFO_FULL=1 -> no flag, DROP_COUNT=1.
REQ-037 SHALL test HOLDOFF=32, second burst at sample 10 after first -> ignored; burst at sample 40 -> second flag.
REQ-038 SHALL test NIOS_ADC_ON dropped mid-DETECT -> IDLE next cycle, DETECTION low, no flag; re-enable clears TIMER to 0.
REQ-039 SHALL test 16400 strobes -> TIMER holds at 16383, TIMER_OVF=1.
